// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter: two-channel valid/ready arbiter feeding a single output
// register. The winner's payload and the select value that chose it are
// registered together, so the pair can drive a 2:1 data mux downstream.
//
// Ports:
//   clk, rst_n         - rising-edge clock, synchronous active-low reset
//   a_data/a_valid     - channel A request (sel = 0); a_ready = accepted
//   b_data/b_valid     - channel B request (sel = 1); b_ready = accepted
//   out_data/out_sel   - registered winning payload and its select
//   out_valid          - output register holds a word
//   out_ready          - downstream takes the word
//
// Build option: define MUX2_ARB_FIXED_PRIO_EN so that ties always go to A.
// When it is left undefined, ties alternate between the two channels.
module mux2_rr_arbiter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             sel_q,   sel_d;
  logic             last_q,  last_d;
  logic             load;
  logic             grant_a;
  logic             grant_b;

  // State and output register; last resets to B so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  // Arbitration and next state. The register can load when it is empty, or
  // when the word it holds leaves during this cycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    grant_a = 1'b0;
    grant_b = 1'b0;
    load    = (state_q == EMPTY) || out_ready;

    if (load) begin
      if (a_valid && b_valid) begin
`ifdef MUX2_ARB_FIXED_PRIO_EN
        grant_a = 1'b1;
`else
        // The channel that did not win last time gets the grant.
        grant_a = last_q;
        grant_b = !last_q;
`endif
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end

      if (grant_a) begin
        state_d = FULL;
        data_d  = a_data;
        sel_d   = 1'b0;
        last_d  = 1'b0;
      end else if (grant_b) begin
        state_d = FULL;
        data_d  = b_data;
        sel_d   = 1'b1;
        last_d  = 1'b1;
      end else begin
        // Word (if any) drained with nothing to replace it; payload holds.
        state_d = EMPTY;
      end
    end
  end

  // Readies are gated by reset so nothing is accepted in a reset cycle.
  assign a_ready   = rst_n && grant_a;
  assign b_ready   = rst_n && grant_b;
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Testbench for mux2_rr_arbiter (WIDTH = 2): table-driven vectors with
// hand-derived expectations, a scoreboard queue for the data path, and a
// short randomised stream checked through the scoreboard.
module tb_mux2_rr_arbiter;

  localparam int unsigned W = 2;
`ifdef MUX2_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] a_data, b_data, out_data;
  logic         a_valid, b_valid, a_ready, b_ready;
  logic         out_sel, out_valid, out_ready;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic         rst_n;
    logic         a_valid;
    logic [W-1:0] a_data;
    logic         b_valid;
    logic [W-1:0] b_data;
    logic         out_ready;
    logic         exp_a_ready;
    logic         exp_b_ready;
    logic         exp_out_valid;
    logic [W-1:0] exp_out_data;
    logic         exp_out_sel;
  } vec_t;

  typedef struct {
    logic [W-1:0] data;
    logic         sel;
  } word_t;

  vec_t  vecs[$];
  word_t sb[$];

  mux2_rr_arbiter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic av, input logic [W-1:0] ad,
                         input logic bv, input logic [W-1:0] bd, input logic ordy,
                         input logic ear, input logic ebr, input logic eov,
                         input logic [W-1:0] eod, input logic eos);
    vec_t v;
    v.rst_n = r; v.a_valid = av; v.a_data = ad; v.b_valid = bv; v.b_data = bd;
    v.out_ready = ordy; v.exp_a_ready = ear; v.exp_b_ready = ebr;
    v.exp_out_valid = eov; v.exp_out_data = eod; v.exp_out_sel = eos;
    vecs.push_back(v);
  endtask

  // Pre-edge scoreboard work: pop on an output transfer, push on an input one.
  task automatic scoreboard_step(input int idx);
    word_t w;
    if (out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow [%0d]: output transfer with empty scoreboard", idx);
      end else begin
        w = sb.pop_front();
        check("sb_data", idx, 32'(out_data), 32'(w.data));
        check("sb_sel", idx, 32'(out_sel), 32'(w.sel));
      end
    end
    if (rst_n && a_valid && a_ready) begin
      w.data = a_data; w.sel = 1'b0; sb.push_back(w);
    end
    if (rst_n && b_valid && b_ready) begin
      w.data = b_data; w.sel = 1'b1; sb.push_back(w);
    end
  endtask

  initial begin
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b0;
    a_data = '0; b_data = '0;

    // rst av ad bv bd ordy | a_rdy b_rdy | out_valid out_data out_sel (after edge)
    // Reset held two cycles with both channels requesting.
    add_vec(0, 1, 2'b01, 1, 2'b11, 1,  0, 0,  0, 2'b00, 0);
    add_vec(0, 1, 2'b01, 1, 2'b11, 1,  0, 0,  0, 2'b00, 0);
    // Tie for four cycles: A first, then alternating (fixed priority: all A).
    add_vec(1, 1, 2'b01, 1, 2'b11, 1,  1, 0,  1, 2'b01, 0);
    add_vec(1, 1, 2'b01, 1, 2'b11, 1,  FP, !FP,  1, FP ? 2'b01 : 2'b11, !FP);
    add_vec(1, 1, 2'b01, 1, 2'b11, 1,  1, 0,  1, 2'b01, 0);
    add_vec(1, 1, 2'b01, 1, 2'b11, 1,  FP, !FP,  1, FP ? 2'b01 : 2'b11, !FP);
    // Drain with nothing new: empty, payload held.
    add_vec(1, 0, 2'b00, 0, 2'b00, 1,  0, 0,  0, FP ? 2'b01 : 2'b11, !FP);
    // Single A word, then empty the following cycle.
    add_vec(1, 1, 2'b01, 0, 2'b00, 1,  1, 0,  1, 2'b01, 0);
    add_vec(1, 0, 2'b00, 0, 2'b00, 1,  0, 0,  0, 2'b01, 0);
    // Back-pressure: load B=10, stall three cycles with A waiting, then release.
    add_vec(1, 0, 2'b00, 1, 2'b10, 1,  0, 1,  1, 2'b10, 1);
    add_vec(1, 1, 2'b01, 0, 2'b00, 0,  0, 0,  1, 2'b10, 1);
    add_vec(1, 1, 2'b01, 0, 2'b00, 0,  0, 0,  1, 2'b10, 1);
    add_vec(1, 1, 2'b01, 0, 2'b00, 0,  0, 0,  1, 2'b10, 1);
    add_vec(1, 1, 2'b01, 0, 2'b00, 1,  1, 0,  1, 2'b01, 0);
    // Hold FULL under back-pressure, then a one-cycle reset discards the word.
    add_vec(1, 0, 2'b00, 0, 2'b00, 0,  0, 0,  1, 2'b01, 0);
    add_vec(0, 1, 2'b01, 1, 2'b11, 0,  0, 0,  0, 2'b00, 0);
    // After reset the first tie goes to A again.
    add_vec(1, 1, 2'b01, 1, 2'b11, 1,  1, 0,  1, 2'b01, 0);
    add_vec(1, 1, 2'b01, 1, 2'b11, 1,  FP, !FP,  1, FP ? 2'b01 : 2'b11, !FP);
    add_vec(1, 0, 2'b00, 0, 2'b00, 1,  0, 0,  0, FP ? 2'b01 : 2'b11, !FP);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n;
      a_valid = vecs[i].a_valid; a_data = vecs[i].a_data;
      b_valid = vecs[i].b_valid; b_data = vecs[i].b_data;
      out_ready = vecs[i].out_ready;
      #1;
      check("a_ready", i, 32'(a_ready), 32'(vecs[i].exp_a_ready));
      check("b_ready", i, 32'(b_ready), 32'(vecs[i].exp_b_ready));
      scoreboard_step(i);
      @(posedge clk);
      #1;
      if (!vecs[i].rst_n) sb.delete();
      check("out_valid", i, 32'(out_valid), 32'(vecs[i].exp_out_valid));
      check("out_data", i, 32'(out_data), 32'(vecs[i].exp_out_data));
      check("out_sel", i, 32'(out_sel), 32'(vecs[i].exp_out_sel));
    end

    // Random traffic with random back-pressure; data checked by the scoreboard.
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      a_valid = 1'($urandom_range(0, 1)); a_data = W'($urandom);
      b_valid = 1'($urandom_range(0, 1)); b_data = W'($urandom);
      out_ready = 1'($urandom_range(0, 3) != 0);
      #1;
      check("one_hot_ready", 100 + n, 32'(a_ready && b_ready), 32'(0));
      check("ready_needs_load", 100 + n,
            32'((a_ready || b_ready) && out_valid && !out_ready), 32'(0));
      check("ready_needs_valid", 100 + n,
            32'((a_ready && !a_valid) || (b_ready && !b_valid)), 32'(0));
      scoreboard_step(100 + n);
      @(posedge clk);
    end

    // Drain whatever is left and confirm the scoreboard empties.
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0; out_ready = 1'b1;
      #1;
      scoreboard_step(200 + n);
      @(posedge clk);
    end
    #1;
    check("final_empty", 300, 32'(out_valid), 32'(0));
    check("sb_leftover", 301, 32'(sb.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
